// File: rtl/dec_pkg.sv
// Shared types and constants for the decoder select arbiter.
// Only the state encodings and decoder geometry live here.
package dec_pkg;

  localparam int unsigned DEC_ADDR_W = 2;
  localparam int unsigned DEC_LINES  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StGrant = 2'd2,
    StGap   = 2'd3
  } dec_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request after the last granted line.
// Purely combinational; all registering happens in the arbiter.
module rr_priority_pick
  import dec_pkg::*;
(
  input  logic [DEC_LINES-1:0]  req_i,
  input  logic [DEC_ADDR_W-1:0] last_i,
  output logic [DEC_ADDR_W-1:0] sel_o,
  output logic                  any_req_o
);

  always_comb begin
    logic [DEC_ADDR_W-1:0] idx;
    idx       = '0;
    sel_o     = '0;
    any_req_o = |req_i;
    // Scan from lowest to highest priority so the nearest requester after last_i wins.
    for (int k = DEC_LINES; k >= 1; k--) begin
      idx = last_i + DEC_ADDR_W'(k);
      if (req_i[idx]) begin
        sel_o = idx;
      end
    end
  end

endmodule

// File: rtl/decoder_select_arbiter.sv
// Round-robin arbiter driving a 2-to-4 select decoder. Address is set up one cycle before
// enable rises and held through a dead-time gap, so the decoder never glitches.
module decoder_select_arbiter
  import dec_pkg::*;
#(
  parameter int unsigned HOLD_MAX   = 8,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DEC_LINES-1:0] req,
  output logic                 address0,
  output logic                 address1,
  output logic                 enable,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] GapMax  = CNT_W'(GAP_CYCLES);

  dec_state_e            state_q, state_d;
  logic [DEC_ADDR_W-1:0] addr_q, addr_d;
  logic [DEC_ADDR_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]      hold_q, hold_d;
  logic [CNT_W-1:0]      gap_q, gap_d;
  logic                  enable_q, enable_d;
  logic                  busy_q, busy_d;

  logic [DEC_ADDR_W-1:0] pick_sel;
  logic                  pick_any;

  rr_priority_pick u_pick (
    .req_i     (req),
    .last_i    (last_q),
    .sel_o     (pick_sel),
    .any_req_o (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    enable_d = enable_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          addr_d  = pick_sel;
          state_d = StSetup;
        end
      end
      StSetup: begin
        // A request withdrawn during setup aborts without touching the pointer.
        if (req[addr_q]) begin
          state_d  = StGrant;
          enable_d = 1'b1;
          last_d   = addr_q;
          hold_d   = CNT_W'(1);
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        if (!req[addr_q] || (hold_q == HoldMax)) begin
          enable_d = 1'b0;
          hold_d   = '0;
          if (GAP_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            gap_d   = CNT_W'(1);
          end
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      StGap: begin
        if (gap_q >= GapMax) begin
          state_d = StIdle;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = StIdle;
        enable_d = 1'b0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      last_q   <= DEC_ADDR_W'(DEC_LINES - 1);
      hold_q   <= '0;
      gap_q    <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
    end
  end

  assign address0 = addr_q[0];
  assign address1 = addr_q[1];
  assign enable   = enable_q;
  assign busy     = busy_q;

endmodule
